// File: rtl/cell_rr_arbiter.sv
// Cell-level round-robin arbiter sharing one forwarding engine among NUM_REQ receive ports.
// Optional per-port grant/timeout statistics are compiled in with `define ARB_STATS_EN.
module cell_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ),
  localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               timeout
`ifdef ARB_STATS_EN
  ,
  input  logic [IDX_W-1:0]   stat_sel,
  input  logic               stat_clr,
  output logic [15:0]        stat_cnt,
  output logic [15:0]        stat_to_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmo_q, tmo_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  int unsigned      cand;

  // Scan ptr+1, ptr+2, ... wrapping at NUM_REQ; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      tmr_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GRANT;
          idx_d   = win_idx;
          tmr_d   = '0;
        end
      end
      ST_GRANT: begin
        // done outranks the watchdog, which outranks a requester drop.
        if (done) begin
          state_d = ST_RELEASE;
          ptr_d   = idx_q;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ST_RELEASE;
          ptr_d   = idx_q;
          tmo_d   = 1'b1;
        end else if (!req[idx_q]) begin
          state_d = ST_RELEASE;
          ptr_d   = idx_q;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Grant is decoded from registered state only, so it is one-hot by construction.
  always_comb begin
    gnt = '0;
    if (state_q == ST_GRANT) gnt[idx_q] = 1'b1;
    gnt_valid = (state_q == ST_GRANT);
    gnt_idx   = idx_q;
    timeout   = tmo_q;
  end

`ifdef ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];
  logic [15:0] to_cnt    [NUM_REQ];
  logic        grant_evt;

  assign grant_evt = (state_q == ST_IDLE) && win_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
        to_cnt[i]    <= '0;
      end
    end else if (stat_clr) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
        to_cnt[i]    <= '0;
      end
    end else begin
      if (grant_evt && grant_cnt[win_idx] != '1)
        grant_cnt[win_idx] <= grant_cnt[win_idx] + 16'd1;
      if (tmo_d && to_cnt[idx_q] != '1)
        to_cnt[idx_q] <= to_cnt[idx_q] + 16'd1;
    end
  end

  always_comb begin
    stat_cnt    = grant_cnt[stat_sel];
    stat_to_cnt = to_cnt[stat_sel];
  end
`endif

endmodule
